cpu_core: RTL and testbench

Parametrised successor to the 8-bit bus computer: a single-module CPU core with PC, MAR, IR, A, B, carry/zero flags, a fixed five-state microsequencer and a ready/valid output port. It adds configurable data and address widths, conditional jumps, immediate load, memory store and output back-pressure. Program memory is external. The core sits between a combinational-read/synchronous-write RAM and an output sink such as a display or test monitor.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/cpu_alu.sv | 27 ++
 rtl/cpu_core.sv | 144 ++++++++++++++
 tb/tb_cpu_core.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the parametrised bus-computer core: opcodes,
// microsequencer states and instruction field helpers.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0   = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    T4   = 3'd4,
    HALT = 3'd5
  } state_e;

  // The opcode always occupies the top nibble of the instruction word.
  function automatic int opcode_lsb(input int data_width);
    return data_width - 4;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational add/subtract unit. On subtract, carry is the no-borrow flag
// (a >= b) so a following JC tests "no borrow".
module cpu_alu #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  sub,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  zero
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] b_ext;
  logic [DATA_WIDTH:0] cin_ext;

  always_comb begin
    b_ext   = sub ? {1'b0, ~b} : {1'b0, b};
    cin_ext = {{DATA_WIDTH{1'b0}}, sub};
    sum     = {1'b0, a} + b_ext + cin_ext;
    result  = sum[DATA_WIDTH-1:0];
    carry   = sum[DATA_WIDTH];
    zero    = (sum[DATA_WIDTH-1:0] == '0);
  end

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle accumulator CPU: five-state microsequencer driving PC, MAR, IR,
// A, B and C/Z flags against an external comb-read / sync-write memory.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  halted,
  output logic [ADDR_WIDTH-1:0] pc_dbg
);

  localparam int OPC_LSB = opcode_lsb(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  c_q, c_d;
  logic                  z_q, z_d;

  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_carry;
  logic                  alu_zero;

  assign opcode  = ir_q[OPC_LSB +: 4];
  assign operand = ir_q[ADDR_WIDTH-1:0];

  // Bits between operand and opcode carry no meaning in this instruction set.
  if (OPC_LSB > ADDR_WIDTH) begin : g_ir_gap
    logic unused_ir_gap;
    assign unused_ir_gap = ^ir_q[OPC_LSB-1:ADDR_WIDTH];
  end

  cpu_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .a      (a_q),
    .b      (b_q),
    .sub    (opcode == OP_SUB),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    z_d     = z_q;

    unique case (state_q)
      T0: begin
        mar_d   = pc_q;
        state_d = T1;
      end
      T1: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = T2;
      end
      T2: begin
        state_d = T3;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_d = operand;
          OP_LDI: a_d = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, operand};
          OP_JMP: pc_d = operand;
          OP_JC:  if (c_q) pc_d = operand;
          OP_JZ:  if (z_q) pc_d = operand;
          OP_OUT: if (!out_ready) state_d = T2;
          OP_HLT: state_d = HALT;
          default: ;
        endcase
      end
      T3: begin
        state_d = T4;
        case (opcode)
          OP_LDA:         a_d = mem_rdata;
          OP_ADD, OP_SUB: b_d = mem_rdata;
          default: ;
        endcase
      end
      T4: begin
        state_d = T0;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          a_d = alu_result;
          c_d = alu_carry;
          z_d = alu_zero;
        end
      end
      HALT: state_d = HALT;
      default: state_d = T0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= T0;
      pc_q    <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      z_q     <= z_d;
    end
  end

  // Strobes decode straight from state so a reset drops them immediately.
  assign mem_we    = (state_q == T3) && (opcode == OP_STA);
  assign out_valid = (state_q == T2) && (opcode == OP_OUT);
  assign halted    = (state_q == HALT);
  assign mem_addr  = mar_q;
  assign mem_wdata = a_q;
  assign out_data  = a_q;
  assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench: an instruction-level reference model predicts the
// per-cycle strobes, PC, accumulator and memory writes of the core.
module tb_cpu_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       halted;
  logic [3:0] pc_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem   [16];
  logic [7:0] m_mem [16];
  logic [3:0] m_pc;
  logic [7:0] m_a, m_b;
  logic       m_c, m_z;

  always #5 clk = ~clk;

  cpu_core #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .halted    (halted),
    .pc_dbg    (pc_dbg)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_model_regs();
    m_pc = 4'd0; m_a = 8'd0; m_b = 8'd0; m_c = 1'b0; m_z = 1'b0;
  endtask

  // Loads m_mem into the RAM under reset and releases reset on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = m_mem[i];
    reset_model_regs();
    @(negedge clk);
    check_eq("rst_strobes", 32'({halted, out_valid, mem_we}), 32'd0);
    check_eq("rst_pc", 32'(pc_dbg), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_acc", 32'(out_data), 32'd0);
    rst = 1'b0;
  endtask

  // Runs one instruction starting at the falling edge before its first cycle.
  task automatic run_instr(input int stall, output bit hlt);
    logic [7:0] ins;
    logic [3:0] op, opd, pc_inc;
    int sum;
    hlt = 1'b0;
    ins = m_mem[m_pc];
    op = ins[7:4];
    opd = ins[3:0];
    pc_inc = m_pc + 4'd1;
    check_eq("fetch_pc", 32'(pc_dbg), 32'(m_pc));
    check_eq("acc", 32'(out_data), 32'(m_a));
    for (int p = 0; p < 2; p++) begin
      check_eq("fetch_strobes", 32'({halted, out_valid, mem_we}), 32'd0);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    if (op == 4'hE) begin
      for (int k = 0; k <= stall; k++) begin
        out_ready = (k == stall);
        check_eq("out_strobes", 32'({out_valid, mem_we}), 32'b10);
        check_eq("out_data", 32'(out_data), 32'(m_a));
        check_eq("out_pc_hold", 32'(pc_dbg), 32'(pc_inc));
        step();
      end
    end else begin
      check_eq("t2_strobes", 32'({halted, out_valid, mem_we}), 32'd0);
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (op == 4'hF) begin
        for (int k = 0; k < 4; k++) begin
          check_eq("halted", 32'(halted), 32'd1);
          check_eq("halt_strobes", 32'({out_valid, mem_we}), 32'd0);
          check_eq("halt_pc", 32'(pc_dbg), 32'(pc_inc));
          check_eq("halt_acc", 32'(out_data), 32'(m_a));
          out_ready = 1'($urandom_range(0, 1));
          step();
        end
        m_pc = pc_inc;
        hlt = 1'b1;
        return;
      end
    end
    check_eq("t3_out_valid", 32'(out_valid), 32'd0);
    check_eq("t3_mem_we", 32'(mem_we), 32'(op == 4'h4));
    if (op == 4'h4) begin
      check_eq("sta_addr", 32'(mem_addr), 32'(opd));
      check_eq("sta_data", 32'(mem_wdata), 32'(m_a));
    end
    out_ready = 1'($urandom_range(0, 1));
    step();
    check_eq("t4_strobes", 32'({halted, out_valid, mem_we}), 32'd0);
    step();
    // Architectural effect of the whole instruction.
    case (op)
      4'h1: m_a = m_mem[opd];
      4'h2: begin
        m_b = m_mem[opd];
        sum = int'(m_a) + int'(m_b);
        m_a = sum[7:0];
        m_c = (sum > 255);
        m_z = (m_a == 8'd0);
      end
      4'h3: begin
        m_b = m_mem[opd];
        m_c = (m_a >= m_b);
        m_a = m_a - m_b;
        m_z = (m_a == 8'd0);
      end
      4'h4: m_mem[opd] = m_a;
      4'h5: m_a = {4'h0, opd};
      4'h6: pc_inc = opd;
      4'h7: if (m_c) pc_inc = opd;
      4'h8: if (m_z) pc_inc = opd;
      default: ;
    endcase
    m_pc = pc_inc;
  endtask

  // stall < 0 picks a random OUT stall per instruction.
  task automatic run_prog(input int max_instr, input int stall);
    bit h;
    for (int i = 0; i < max_instr; i++) begin
      run_instr((stall < 0) ? int'($urandom_range(0, 3)) : stall, h);
      if (h) break;
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    // Add and output.
    clear_prog();
    m_mem[0] = 8'h1E; m_mem[1] = 8'h2F; m_mem[2] = 8'hE0; m_mem[3] = 8'hF0;
    m_mem[14] = 8'd28; m_mem[15] = 8'd14;
    do_reset();
    run_prog(10, 0);

    // Overflow to zero with carry; taken JC, then OUT of A and a JZ.
    clear_prog();
    m_mem[0] = 8'h1E; m_mem[1] = 8'h2F; m_mem[2] = 8'h79;
    m_mem[9] = 8'hE0; m_mem[10] = 8'h8C; m_mem[11] = 8'hF0; m_mem[12] = 8'hF0;
    m_mem[14] = 8'hFF; m_mem[15] = 8'h01;
    do_reset();
    run_prog(10, 0);

    // Subtract with borrow; JC not taken.
    clear_prog();
    m_mem[0] = 8'h55; m_mem[1] = 8'h3F; m_mem[2] = 8'h70; m_mem[3] = 8'hE0;
    m_mem[4] = 8'hF0; m_mem[15] = 8'd7;
    do_reset();
    run_prog(10, 0);

    // Output back-pressure: three stalled cycles.
    clear_prog();
    m_mem[0] = 8'h57; m_mem[1] = 8'hE0; m_mem[2] = 8'hF0;
    do_reset();
    run_prog(10, 3);

    // Store, reload and PC wrap through a trailing NOP at 15.
    clear_prog();
    m_mem[0] = 8'h59; m_mem[1] = 8'h4D; m_mem[2] = 8'h1D; m_mem[3] = 8'h6F;
    do_reset();
    run_prog(9, 0);

    // Reset during T3 of an STA must suppress the write.
    clear_prog();
    m_mem[0] = 8'h59; m_mem[1] = 8'h4D; m_mem[2] = 8'hF0;
    do_reset();
    run_prog(1, 0);
    check_eq("sta_fetch_pc", 32'(pc_dbg), 32'd1);
    step(); step(); step();
    check_eq("sta_we_armed", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_strobes", 32'({halted, out_valid, mem_we}), 32'd0);
    check_eq("abort_pc", 32'(pc_dbg), 32'd0);
    check_eq("abort_addr", 32'(mem_addr), 32'd0);
    check_eq("abort_acc", 32'(out_data), 32'd0);
    @(negedge clk);
    step();
    check_eq("abort_no_write", 32'(mem[13]), 32'd0);
    reset_model_regs();
    rst = 1'b0;
    run_prog(5, 0);

    // Random programs with random back-pressure.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'($urandom);
      do_reset();
      run_prog(25, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
